// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: issues fetched instructions then injects per-class NOP bubbles while holding fetch.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int INSTR_W = 32,
    parameter int CNT_W = 6,
    parameter int BRANCH_STALL = 3,
    parameter int ALU_STALL = 3,
    parameter int DIV_STALL = 34,
    parameter int LOAD_STALL = 3,
    parameter int OTHER_STALL = 0,
    parameter logic [INSTR_W-1:0] NOP_WORD = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
`ifdef HAZARD_STATS_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        issued_count,
`endif
    output logic               stay
);
    if (BRANCH_STALL >= 2**CNT_W || ALU_STALL >= 2**CNT_W || DIV_STALL >= 2**CNT_W ||
        LOAD_STALL >= 2**CNT_W || OTHER_STALL >= 2**CNT_W) begin : g_bad_cfg
        $error("hazard_stall_ctrl: a stall depth does not fit in CNT_W bits");
    end
    localparam logic [CNT_W-1:0] B_N = CNT_W'(BRANCH_STALL);
    localparam logic [CNT_W-1:0] A_N = CNT_W'(ALU_STALL);
    localparam logic [CNT_W-1:0] D_N = CNT_W'(DIV_STALL);
    localparam logic [CNT_W-1:0] L_N = CNT_W'(LOAD_STALL);
    localparam logic [CNT_W-1:0] O_N = CNT_W'(OTHER_STALL);
    logic [5:0] op, funct;
    logic [CNT_W-1:0] cnt, n;
    logic busy;
    assign op = instr[INSTR_W-1 -: 6];
    assign funct = instr[5:0];
    assign busy = cnt != '0;
    always_comb begin
        n = (op == 6'd2 || op == 6'd4 || op == 6'd5) ? B_N :
            (op == 6'd0) ? ((funct == 6'd26 || funct == 6'd27) ? D_N : A_N) :
            (op == 6'd35) ? L_N :
            (op == 6'd63) ? '0 : O_N;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out <= NOP_WORD;
            instr_valid <= 1'b0;
            stay <= 1'b0;
            cnt <= '0;
        end else if (flush) begin
            instr_out <= NOP_WORD;
            instr_valid <= 1'b0;
            stay <= 1'b0;
            cnt <= '0;
        end else if (busy) begin
            instr_out <= NOP_WORD;
            instr_valid <= 1'b0;
            stay <= cnt != CNT_W'(1);
            cnt <= cnt - 1'b1;
        end else begin
            instr_out <= instr;
            instr_valid <= op != 6'd63;
            stay <= n != '0;
            cnt <= n;
        end
    end
`ifdef HAZARD_STATS_EN
    // a flush edge also emits a bubble; both counters stick at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else begin
            if ((flush || busy) && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
            if (!flush && !busy && op != 6'd63 && ~&issued_count) issued_count <= issued_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of issue, bubble count, flush, reset and back-to-back stalls.
module tb_hazard_stall_ctrl;
    localparam logic [31:0] NOP = 32'hFFFF_FFFF, BEQ = 32'h1000_0000, DIVU = 32'h0000_001B,
        ORI = 32'h3400_0000, SW = 32'hAC00_0000, LW = 32'h8C00_0000, J = 32'h0800_0000,
        ADD = 32'h0000_0020;
    logic clk = 1'b0;
    logic rst, flush, flush2;
    logic [31:0] instr, instr2, o, o2;
    logic v, s, v2, s2;
    int checks = 0, failures = 0;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc, ic, sc2, ic2;
`endif
    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .flush(flush),
        .instr_out(o), .instr_valid(v),
`ifdef HAZARD_STATS_EN
        .stall_cycles(sc), .issued_count(ic),
`endif
        .stay(s)
    );

    hazard_stall_ctrl #(.LOAD_STALL(5)) dut2 (
        .clk(clk), .rst(rst), .instr(instr2), .flush(flush2),
        .instr_out(o2), .instr_valid(v2),
`ifdef HAZARD_STATS_EN
        .stall_cycles(sc2), .issued_count(ic2),
`endif
        .stay(s2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; flush2 = 1'b0; instr = NOP; instr2 = NOP;
        #12;
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: out=%h valid=%b stay=%b, want %h 0 0", o, v, s, NOP);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        instr = BEQ;
        tick();
        checks++;
        if ({o, v, s} !== {BEQ, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL beq_issue: out=%h valid=%b stay=%b, want %h 1 1", o, v, s, BEQ);
        end
        tick();
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL beq_bubble1: out=%h valid=%b stay=%b, want %h 0 1", o, v, s, NOP);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: out=%h valid=%b stay=%b, want %h 0 0", o, v, s, NOP);
        end
        tick();
        rst = 1'b0; instr = ORI;
        tick();
        checks++;
        if ({o, v, s} !== {ORI, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_issue: out=%h valid=%b stay=%b, want %h 1 0", o, v, s, ORI);
        end
    endtask

    task automatic test_divu;
        instr = DIVU;
        tick();
        checks++;
        if ({o, v, s} !== {DIVU, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL divu_issue: out=%h valid=%b stay=%b, want %h 1 1", o, v, s, DIVU);
        end
        for (int i = 1; i <= 34; i++) begin
            tick();
            checks++;
            if ({o, v, s} !== {NOP, 1'b0, i != 34}) begin
                failures++;
                $display("FAIL divu_bubble%0d: out=%h valid=%b stay=%b, want %h 0 %b", i, o, v, s, NOP, i != 34);
            end
        end
        instr = SW;
        tick();
        checks++;
        if ({o, v, s} !== {SW, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL divu_next: out=%h valid=%b stay=%b, want %h 1 0", o, v, s, SW);
        end
    endtask

    task automatic test_other;
        instr = ORI;
        tick();
        checks++;
        if ({o, v, s} !== {ORI, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ori_issue: out=%h valid=%b stay=%b, want %h 1 0", o, v, s, ORI);
        end
        instr = SW;
        tick();
        checks++;
        if ({o, v, s} !== {SW, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sw_issue: out=%h valid=%b stay=%b, want %h 1 0", o, v, s, SW);
        end
        instr = NOP;
        tick();
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL nop_issue: out=%h valid=%b stay=%b, want %h 0 0", o, v, s, NOP);
        end
    endtask

    task automatic test_back_to_back;
        instr2 = LW;
        tick();
        checks++;
        if ({o2, v2, s2} !== {LW, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL lw_issue: out=%h valid=%b stay=%b, want %h 1 1", o2, v2, s2, LW);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({o2, v2, s2} !== {NOP, 1'b0, i != 5}) begin
                failures++;
                $display("FAIL lw_bubble%0d: out=%h valid=%b stay=%b, want %h 0 %b", i, o2, v2, s2, NOP, i != 5);
            end
        end
        instr2 = J;
        tick();
        checks++;
        if ({o2, v2, s2} !== {J, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL j_issue: out=%h valid=%b stay=%b, want %h 1 1", o2, v2, s2, J);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({o2, v2, s2} !== {NOP, 1'b0, i != 3}) begin
                failures++;
                $display("FAIL j_bubble%0d: out=%h valid=%b stay=%b, want %h 0 %b", i, o2, v2, s2, NOP, i != 3);
            end
        end
        instr2 = ORI;
        tick();
        checks++;
        if ({o2, v2, s2} !== {ORI, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL j_next: out=%h valid=%b stay=%b, want %h 1 0", o2, v2, s2, ORI);
        end
        instr2 = NOP;
    endtask

    task automatic test_flush;
        instr = DIVU;
        tick();
        for (int i = 1; i <= 9; i++) tick();
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL pre_flush_bubble9: out=%h valid=%b stay=%b, want %h 0 1", o, v, s, NOP);
        end
        flush = 1'b1;
        tick();
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL flush_edge: out=%h valid=%b stay=%b, want %h 0 0", o, v, s, NOP);
        end
        flush = 1'b0; instr = ADD;
        tick();
        checks++;
        if ({o, v, s} !== {ADD, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL post_flush_issue: out=%h valid=%b stay=%b, want %h 1 1", o, v, s, ADD);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({o, v, s} !== {NOP, 1'b0, i != 3}) begin
                failures++;
                $display("FAIL add_bubble%0d: out=%h valid=%b stay=%b, want %h 0 %b", i, o, v, s, NOP, i != 3);
            end
        end
        instr = ORI; flush = 1'b1;
        tick();
        checks++;
        if ({o, v, s} !== {NOP, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_flush_discard: out=%h valid=%b stay=%b, want %h 0 0", o, v, s, NOP);
        end
        flush = 1'b0; instr = NOP;
        tick();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        tick();
        rst = 1'b0; instr = ADD;
        tick();
        instr = BEQ;
        for (int i = 0; i < 3; i++) tick();
        tick();
        instr = ORI;
        for (int i = 0; i < 3; i++) tick();
        tick();
        instr = NOP;
        checks++;
        if (ic !== 32'd3 || sc !== 32'd6) begin
            failures++;
            $display("FAIL stats: issued=%0d stalls=%0d, want 3 6", ic, sc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_stall();
        test_divu();
        test_other();
        test_back_to_back();
        test_flush();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
